// File: rtl/map_pkg.sv
// Shared definitions for the tile-map viewport reader.
// Holds map geometry, field widths, block-state and reader-FSM typedefs,
// and the scroll-column fold helper.
package map_pkg;

    localparam int MAP_ROWS  = 5;
    localparam int MAP_COLS  = 100;
    localparam int VIEW_COLS = 20;
    localparam int CELL_PX   = 8;

    localparam int ROW_W   = 3;
    localparam int COL_W   = 7;
    localparam int CX_W    = $clog2(VIEW_COLS);
    localparam int PX_W    = $clog2(CELL_PX);
    localparam int CLR_W   = 4;
    localparam int STATE_W = 3;
    localparam int RGB_W   = 3 * CLR_W;

    localparam logic [PX_W-1:0]  PX_LAST   = PX_W'(CELL_PX - 1);
    localparam logic [CX_W-1:0]  CX_LAST   = CX_W'(VIEW_COLS - 1);
    localparam logic [ROW_W-1:0] CY_LAST   = ROW_W'(MAP_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(MAP_COLS - 1);
    localparam logic [COL_W-1:0] COL_COUNT = COL_W'(MAP_COLS);

    typedef enum logic [STATE_W-1:0] {
        BLK_EMPTY   = 3'b000,
        BLK_SOLID   = 3'b001,
        BLK_SPECIAL = 3'b010
    } block_state_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    // A 7-bit scroll value can exceed the map width by at most 27,
    // so one conditional subtract brings it back into range.
    function automatic logic [COL_W-1:0] fold_col(input logic [COL_W-1:0] c);
        return (c >= COL_COUNT) ? c - COL_COUNT : c;
    endfunction

endpackage

// File: rtl/map_view_counter.sv
// Nested viewport walker: px (pixel in cell) -> cx (view cell) ->
// py (pixel line in cell) -> cy (map row). Tracks the wrapped map column
// incrementally so no modulo is needed.
// Optional macro MAP_VIEW_GRID_EN: when defined, 'blank' flags the first
// pixel column/line of each cell; otherwise 'blank' is tied low.
// Ports:
//   clk, rst          clock, async active-high reset
//   clear, start_col  restart walk at pixel 0 with base column start_col
//   advance           step to the next pixel
//   col, cy           current map column / row
//   first, line_end, last  flags for the current pixel
//   blank             grid-line pixel
module map_view_counter
    import map_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    input  logic [COL_W-1:0] start_col,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] cy,
    output logic             first,
    output logic             line_end,
    output logic             last,
    output logic             blank
);

    logic [PX_W-1:0]  px;
    logic [PX_W-1:0]  py;
    logic [CX_W-1:0]  cx;
    logic [COL_W-1:0] base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px   <= '0;
            py   <= '0;
            cx   <= '0;
            cy   <= '0;
            col  <= '0;
            base <= '0;
        end else if (clear) begin
            px   <= '0;
            py   <= '0;
            cx   <= '0;
            cy   <= '0;
            col  <= start_col;
            base <= start_col;
        end else if (advance) begin
            if (px != PX_LAST) begin
                px <= px + 1'b1;
            end else begin
                px <= '0;
                if (cx != CX_LAST) begin
                    cx  <= cx + 1'b1;
                    col <= (col == COL_LAST) ? '0 : col + 1'b1;
                end else begin
                    cx  <= '0;
                    col <= base;
                    if (py != PX_LAST) begin
                        py <= py + 1'b1;
                    end else begin
                        py <= '0;
                        cy <= (cy == CY_LAST) ? '0 : cy + 1'b1;
                    end
                end
            end
        end
    end

    assign first    = (px == '0) && (py == '0) && (cx == '0) && (cy == '0);
    assign line_end = (px == PX_LAST) && (cx == CX_LAST);
    assign last     = line_end && (py == PX_LAST) && (cy == CY_LAST);

`ifdef MAP_VIEW_GRID_EN
    assign blank = (px == '0) || (py == '0);
`else
    assign blank = 1'b0;
`endif

endmodule

// File: rtl/map_view_reader.sv
// Reads a scrolled viewport of the tile map and emits it as a raster
// pixel stream (each cell expanded to CELL_PX x CELL_PX) with valid/ready.
// Optional macro MAP_VIEW_GRID_EN (see map_view_counter) blanks grid pixels.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, scroll_col, busy  frame request / leftmost column / in progress
//   map_y, map_x             cell address to the map
//   map_r/g/b, map_state     map response (combinational from address)
//   pix_valid, pix_ready     output handshake
//   pix_rgb, pix_state       pixel colour / cell block state
//   pix_sof, pix_eol         first pixel of frame / last pixel of line
//   frame_done               pulse after the final pixel is accepted
//
// state    | meaning
// RD_IDLE  | waiting for start
// RD_RUN   | loading pixels into the output register
// RD_DRAIN | last pixel loaded, waiting for its acceptance
module map_view_reader
    import map_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COL_W-1:0]   scroll_col,
    output logic               busy,
    output logic [ROW_W-1:0]   map_y,
    output logic [COL_W-1:0]   map_x,
    input  logic [CLR_W-1:0]   map_r,
    input  logic [CLR_W-1:0]   map_g,
    input  logic [CLR_W-1:0]   map_b,
    input  logic [STATE_W-1:0] map_state,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [RGB_W-1:0]   pix_rgb,
    output logic [STATE_W-1:0] pix_state,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               frame_done
);

    rd_state_t state;
    logic      start_ok;
    logic      load;
    logic      first;
    logic      line_end;
    logic      last;
    logic      blank;

    assign start_ok = (state == RD_IDLE) && start;
    // Output register refills when empty or when its pixel leaves this cycle.
    assign load     = (state == RD_RUN) && (!pix_valid || pix_ready);

    map_view_counter u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (start_ok),
        .advance   (load),
        .start_col (fold_col(scroll_col)),
        .col       (map_x),
        .cy        (map_y),
        .first     (first),
        .line_end  (line_end),
        .last      (last),
        .blank     (blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RD_IDLE;
            busy       <= 1'b0;
            pix_valid  <= 1'b0;
            pix_rgb    <= '0;
            pix_state  <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= RD_RUN;
                    end
                end
                RD_RUN: begin
                    if (load) begin
                        pix_valid <= 1'b1;
                        pix_rgb   <= blank ? '0 : {map_r, map_g, map_b};
                        pix_state <= map_state;
                        pix_sof   <= first;
                        pix_eol   <= line_end;
                        if (last) begin
                            state <= RD_DRAIN;
                        end
                    end
                end
                RD_DRAIN: begin
                    if (pix_valid && pix_ready) begin
                        pix_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= RD_IDLE;
                    end
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_view_reader.sv
// Directed bench for map_view_reader: models the tile map, consumes the
// pixel stream and compares every accepted pixel plus hand-picked points.
module tb_map_view_reader;

`ifdef MAP_VIEW_GRID_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  scroll_col;
    logic        busy;
    logic [2:0]  map_y;
    logic [6:0]  map_x;
    logic [3:0]  map_r, map_g, map_b;
    logic [2:0]  map_state;
    logic        pix_valid;
    logic        pix_ready;
    logic [11:0] pix_rgb;
    logic [2:0]  pix_state;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] got [6400];

    always #5 clk = ~clk;

    map_view_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .scroll_col (scroll_col),
        .busy       (busy),
        .map_y      (map_y),
        .map_x      (map_x),
        .map_r      (map_r),
        .map_g      (map_g),
        .map_b      (map_b),
        .map_state  (map_state),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_rgb    (pix_rgb),
        .pix_state  (pix_state),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .frame_done (frame_done)
    );

    // Map content: colour depends on row, block state on column.
    function automatic logic [11:0] row_rgb(input logic [2:0] y);
        case (y)
            3'd0:    return 12'hF00;
            3'd1:    return 12'h0F0;
            3'd2:    return 12'h00F;
            3'd3:    return 12'hFF0;
            3'd4:    return 12'hF0F;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [2:0] col_state(input int x);
        if (x % 5 == 0)      return 3'd2;
        else if (x % 4 == 3) return 3'd1;
        else                 return 3'd0;
    endfunction

    assign {map_r, map_g, map_b} = row_rgb(map_y);
    assign map_state = col_state(int'(map_x));

    function automatic logic [16:0] exp_pix(input int base, input int n);
        int line, pos, cx, px, cy, py, col;
        logic [11:0] rgb;
        line = n / 160;
        pos  = n % 160;
        cx   = pos / 8;
        px   = pos % 8;
        cy   = line / 8;
        py   = line % 8;
        col  = (base + cx) % 100;
        rgb  = row_rgb(3'(cy));
        if (GRID && (px == 0 || py == 0)) rgb = 12'h000;
        return {rgb, col_state(col), n == 0, pos == 159};
    endfunction

    function automatic logic [16:0] pk(input logic [11:0] rgb, input logic [2:0] st,
                                       input logic sof, input logic eol);
        return {rgb, st, sof, eol};
    endfunction

    function automatic logic [11:0] g(input logic [11:0] rgb);
        return GRID ? 12'h000 : rgb;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int scroll, input int stall_at,
                             input int busy_start_at, input int rst_at);
        int base, n, n_done, stall_cnt, cyc;
        logic [16:0] snap, obs;
        base = (scroll >= 100) ? scroll - 100 : scroll;
        n = 0;
        n_done = 0;
        stall_cnt = 0;
        snap = '0;
        for (int i = 0; i < 6400; i++) got[i] = '1;

        @(negedge clk);
        scroll_col = 7'(scroll);
        start = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scroll_col = 7'(scroll + 37);
        check_val("lat1_valid", pix_valid, 0);
        check_val("lat1_busy", busy, 1);
        @(negedge clk);
        check_val("lat2_valid", pix_valid, 1);

        for (cyc = 0; cyc < 8000 && n_done == 0; cyc++) begin
            if (n == rst_at) begin
                rst = 1'b1;
                #1;
                check_val("rst_outputs",
                          {busy, pix_valid, pix_rgb, pix_state, pix_sof, pix_eol,
                           frame_done, map_y, map_x}, 0);
                @(negedge clk);
                rst = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    if (frame_done) n_done++;
                end
                check_val("rst_no_done", n_done, 0);
                check_val("rst_idle_valid", pix_valid, 0);
                return;
            end
            obs = {pix_rgb, pix_state, pix_sof, pix_eol};
            start = (n == busy_start_at);
            pix_ready = 1'b1;
            if (n == stall_at && pix_valid && stall_cnt < 4) begin
                if (stall_cnt == 0) snap = obs;
                else                check_val("stall_hold", obs, snap);
                if (stall_cnt < 3) pix_ready = 1'b0;
                stall_cnt++;
            end
            if (frame_done) begin
                n_done++;
                check_val("done_after_all", n, 6400);
            end
            if (pix_valid && pix_ready) begin
                check_val($sformatf("pix%0d", n), obs, exp_pix(base, n));
                if (n < 6400) got[n] = obs;
                n++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val("frame_done_seen", n_done, 1);
        check_val("accept_count", n, 6400);
        repeat (5) begin
            if (frame_done) n_done++;
            @(negedge clk);
        end
        check_val("done_once", n_done, 1);
        check_val("idle_busy", busy, 0);
        check_val("idle_valid", pix_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_ready = 1'b0;
        scroll_col = '0;
        repeat (3) @(negedge clk);
        check_val("reset_state",
                  {busy, pix_valid, pix_rgb, pix_state, pix_sof, pix_eol,
                   frame_done, map_y, map_x}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_val("post_reset_busy", busy, 0);
        check_val("post_reset_valid", pix_valid, 0);

        // scroll 0, ready always high
        run_frame(0, -1, -1, -1);
        check_val("A_p0",     got[0],    pk(g(12'hF00), 3'd2, 1'b1, 1'b0));
        check_val("A_p8",     got[8],    pk(g(12'hF00), 3'd0, 1'b0, 1'b0));
        check_val("A_p159",   got[159],  pk(g(12'hF00), 3'd1, 1'b0, 1'b1));
        check_val("A_l16",    got[2560], pk(g(12'h00F), 3'd2, 1'b0, 1'b0));
        check_val("A_l17p8",  got[2728], pk(g(12'h00F), 3'd0, 1'b0, 1'b0));
        check_val("A_l17p9",  got[2729], pk(12'h00F,    3'd0, 1'b0, 1'b0));
        check_val("A_l32p1",  got[5121], pk(g(12'hF0F), 3'd2, 1'b0, 1'b0));
        check_val("A_l33p1",  got[5281], pk(12'hF0F,    3'd2, 1'b0, 1'b0));
        check_val("A_last",   got[6399], pk(12'hF0F,    3'd1, 1'b0, 1'b1));

        // scroll 95, column wrap inside the line
        run_frame(95, -1, -1, -1);
        check_val("B_p3",    got[3],   pk(g(12'hF00), 3'd2, 1'b0, 1'b0));
        check_val("B_p32",   got[32],  pk(g(12'hF00), 3'd1, 1'b0, 1'b0));
        check_val("B_p40",   got[40],  pk(g(12'hF00), 3'd2, 1'b0, 1'b0));
        check_val("B_p159",  got[159], pk(g(12'hF00), 3'd0, 1'b0, 1'b1));
        check_val("B_l1p33", got[193], pk(12'hF00,    3'd1, 1'b0, 1'b0));

        // scroll 100 folds to 0; stall at pixel 50; start while busy
        run_frame(100, 50, 1000, -1);
        check_val("C_p0",   got[0],   pk(g(12'hF00), 3'd2, 1'b1, 1'b0));
        check_val("C_p50",  got[50],  pk(g(12'hF00), 3'd0, 1'b0, 1'b0));
        check_val("C_p51",  got[51],  pk(g(12'hF00), 3'd0, 1'b0, 1'b0));
        check_val("C_p159", got[159], pk(g(12'hF00), 3'd1, 1'b0, 1'b1));

        // reset mid-frame, then a clean frame
        run_frame(0, -1, -1, 3000);
        run_frame(0, -1, -1, -1);
        check_val("E_p0", got[0], pk(g(12'hF00), 3'd2, 1'b1, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
